key_conditioner: RTL
====================

# key_conditioner

Input-side counterpart of the Tetris display/score output path. It turns the four raw push-button pins (down, left, right, rotate) into clean, handshaked game commands for the `game` core's `op` input. The path is polarity normalization, a 2-flop synchronizer, tick-based debounce, press-edge detection and hold-to-repeat for the movement keys. It replaces the ad-hoc pin inversion at the top level.

## Interface
Parameters:
- `DIV`, 50000: clk cycles per sample tick (1 kHz at 50 MHz); must be ≥2.
- `DEB_TICKS`, 8: consecutive disagreeing ticks needed to flip a debounced level; must be ≥1.
- `REP_DELAY`, 300: ticks from first press event to first repeat event.
- `REP_RATE`, 100: ticks between subsequent repeat events.
- `POL`, 4'b1100: per-key input polarity, 1 = active-low pin; bit order {down,left,right,rotate}.
- `REPEAT_MASK`, 4'b1110: 1 = key auto-repeats while held; rotate is single-shot.

Ports:
- `clk` in 1: system clock; sole clock.
- `reset` in 1: asynchronous, active-high reset.
- `btn_in` in 4: raw pins {down,left,right,rotate}, asynchronous to clk.
- `op` out 4: pending command bits, same order, active-high; sticky until acknowledged.
- `op_ack` in 1: consumer has taken `op`; clears the bits that were set in the previous cycle.
- `held` out 4: debounced, normalized key levels.
- `tick` out 1: one-cycle sample strobe, for use by other slow logic.

## Operation
- Normalize: `n = btn_in ^ POL`, so 1 = pressed. Synchronize through 2 flops. Only the second flop's output `s` is used downstream.
- Prescaler: counter 0..DIV-1, wraps to 0. `tick` = 1 in the cycle the count equals DIV-1.
- Debounce, per key, on tick only:
  - If `s != held`, the disagree counter increments; when it reaches DEB_TICKS, `held` flips and the counter clears.
  - If `s == held`, the counter clears.
  - A glitch shorter than DEB_TICKS ticks never changes `held`.
- Per-key FSM, states IDLE / PRESS / REPEAT:
  - IDLE: on `held` rising, raise an event, go to PRESS, clear the repeat counter.
  - PRESS: on tick, the counter increments. If REPEAT_MASK=1 and the counter reaches REP_DELAY, raise an event, go to REPEAT and clear the counter. If REPEAT_MASK=0, the key stays in PRESS and raises no further events.
  - REPEAT: on tick, the counter increments. On reaching REP_RATE, raise an event and clear the counter.
  - Any state: `held`=0 sends the key to IDLE and clears its counter in the same cycle; no event is raised.
- Command register, per bit, each cycle:
  - `op[i]` is set when key i raises an event.
  - Otherwise `op[i]` clears when `op_ack`=1 and `op[i]` was already 1.
  - A new event in the same cycle as ack wins, so the bit stays 1 and the event is not lost.
  - Repeated events on an unacked bit merge into one pending command; there is no counting.
- Keys are fully independent. Several `op` bits may be set at once, and the consumer resolves priority.
- Counter widths: $clog2(max+1) of their respective limits. Counters saturate-free because they clear at their limits.

## Timing
- Reset values: `op`=0, `held`=0, `tick`=0, all FSMs IDLE, all counters 0, synchronizer flops 0 (normalized "released"). Reset is asynchronous mid-operation; on release, a key that is still pressed must re-debounce (DEB_TICKS ticks) before generating its event.
- Latency from a stable press to `op` high: 2 sync cycles, plus DEB_TICKS ticks, plus 1 cycle from the `held` edge to `op` set.
- Release latency: `held` falls after DEB_TICKS stable-released ticks. The FSM is IDLE on the next cycle.
- Handshake: `op` is a registered output. `op_ack` is sampled on the clk edge, and bits clear in the following cycle. Asserting `op_ack` while `op`=0 has no effect.
- `tick` and the debounce sample act in the same cycle; the FSM sees the new `held` one cycle later.

## Test plan
Use DIV=4, DEB_TICKS=3, REP_DELAY=5, REP_RATE=2 and default POL/REPEAT_MASK.
- Reset: assert `reset` asynchronously mid-count → `op`=0, `held`=0 and `tick`=0 immediately. After release, `tick` pulses every 4 cycles.
- Debounce: press `right` (pin 1) for 2 ticks, then release → `held`/`op` stay 0. Hold it for 3 ticks → `held[1]`=1 and `op[1]`=1 one cycle later.
- Polarity and single-shot: drive `btn_in[3]` (down) to 0 → `op[3]` pulses the press event. Ack it, then hold `rotate` for 40 ticks → exactly one `op[0]` event.
- Repeat: hold `left`, acking each event → events at press, at press+5 ticks, then every 2 ticks. Release → no further events after `held` falls.
- Ack collision: assert `op_ack` in the same cycle a repeat event fires on that key → `op` bit remains 1. A following ack with no event clears it.
- Multi-key: press down and right together → both `op[3]` and `op[1]` set in the same cycle. One ack clears both.

Source files
------------

// File: rtl/key_conditioner_if.sv
// Command handshake between key_conditioner and its consumer.
// op is sticky until the consumer pulses op_ack.
interface key_conditioner_if;
  logic [3:0] op;
  logic       op_ack;

  modport master (
    output op,
    input  op_ack
  );

  modport slave (
    input  op,
    output op_ack
  );
endinterface

// File: rtl/key_conditioner.sv
// Push-button conditioner: polarity, sync, debounce, press edge,
// hold-to-repeat, and a sticky command register with ack.
module key_conditioner #(
  parameter int         DIV         = 50000,
  parameter int         DEB_TICKS   = 8,
  parameter int         REP_DELAY   = 300,
  parameter int         REP_RATE    = 100,
  parameter logic [3:0] POL         = 4'b1100,
  parameter logic [3:0] REPEAT_MASK = 4'b1110
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        btn_in,
  key_conditioner_if.master cmd,
  output logic [3:0]        held,
  output logic              tick
);

  localparam int PW   = $clog2(DIV);
  localparam int DW   = $clog2(DEB_TICKS + 1);
  localparam int RMAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    REPEAT
  } st_t;

  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [PW-1:0] r_div;
  logic          w_tick;
  logic [3:0]    r_held;
  logic [DW-1:0] r_deb [4];
  st_t           r_st [4];
  st_t           w_st_nxt [4];
  logic [RW-1:0] r_rep [4];
  logic [RW-1:0] w_rep_nxt [4];
  logic [3:0]    w_ev;
  logic [3:0]    r_op;

  assign w_tick  = (r_div == PW'(DIV - 1));
  assign tick    = w_tick;
  assign held    = r_held;
  assign cmd.op  = r_op;

  // Flops reset to 0, i.e. normalized "released".
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_in ^ POL;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_held <= '0;
      for (int k = 0; k < 4; k++) begin
        r_deb[k] <= '0;
      end
    end else if (w_tick) begin
      for (int k = 0; k < 4; k++) begin
        if (r_sync2[k] != r_held[k]) begin
          if (r_deb[k] == DW'(DEB_TICKS - 1)) begin
            r_held[k] <= ~r_held[k];
            r_deb[k]  <= '0;
          end else begin
            r_deb[k] <= r_deb[k] + 1'b1;
          end
        end else begin
          r_deb[k] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        r_st[k]  <= IDLE;
        r_rep[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        r_st[k]  <= w_st_nxt[k];
        r_rep[k] <= w_rep_nxt[k];
      end
    end
  end

  // A released key wins over every state and never raises an event.
  always_comb begin
    w_ev = '0;
    for (int k = 0; k < 4; k++) begin
      w_st_nxt[k]  = r_st[k];
      w_rep_nxt[k] = r_rep[k];
      if (!r_held[k]) begin
        w_st_nxt[k]  = IDLE;
        w_rep_nxt[k] = '0;
      end else begin
        unique case (r_st[k])
          IDLE: begin
            w_ev[k]      = 1'b1;
            w_st_nxt[k]  = PRESS;
            w_rep_nxt[k] = '0;
          end
          PRESS: begin
            if (w_tick && REPEAT_MASK[k]) begin
              if (r_rep[k] == RW'(REP_DELAY - 1)) begin
                w_ev[k]      = 1'b1;
                w_st_nxt[k]  = REPEAT;
                w_rep_nxt[k] = '0;
              end else begin
                w_rep_nxt[k] = r_rep[k] + 1'b1;
              end
            end
          end
          REPEAT: begin
            if (w_tick) begin
              if (r_rep[k] == RW'(REP_RATE - 1)) begin
                w_ev[k]      = 1'b1;
                w_rep_nxt[k] = '0;
              end else begin
                w_rep_nxt[k] = r_rep[k] + 1'b1;
              end
            end
          end
          default: begin
            w_st_nxt[k]  = IDLE;
            w_rep_nxt[k] = '0;
          end
        endcase
      end
    end
  end

  // A fresh event beats a same-cycle ack so no command is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op <= '0;
    end else begin
      r_op <= w_ev | (r_op & ~{4{cmd.op_ack}});
    end
  end

endmodule
